// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: column strobe, row synchronizer, scan-level debounce, hex key shift register.
// Optional auto-repeat while a key is held is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner_4x4 #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 8
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  input  logic        clear,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] value,
  output logic [1:0]  dbg_state
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  // Handshake: key_valid is a one-cycle strobe with no ready; key_code and
  // value are already updated in the same cycle key_valid is high.

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [3:0]    rows_s;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          sample;
  logic          scan_end;
  logic          col_hit;
  logic [1:0]    hit_row;
  logic          seen;
  logic [3:0]    seen_code;
  logic          res_valid;
  logic [3:0]    res_code;
  logic [3:0]    cand;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] rel_cnt;
  logic          accept;
  logic          rep_fire;
  logic          emit;
  logic [3:0]    emit_code;

  // Synchronizer idles at "no key" so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  assign rows_s = ~row_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= 2'd0;
    end else if (dwell == DWELL_LAST) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  assign col       = 4'b0001 << col_idx;
  assign sample    = (dwell == DWELL_LAST);
  assign scan_end  = sample && (col_idx == 2'd3);
  assign dbg_state = state;

  always_comb begin
    col_hit = |rows_s;
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (rows_s[r]) hit_row = 2'(r);
    end
  end

  // The current column's sample is folded in so the last column counts at scan end.
  assign res_valid = seen | col_hit;
  assign res_code  = seen ? seen_code : {hit_row, col_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= 1'b0;
      seen_code <= 4'h0;
    end else if (sample) begin
      if (scan_end) begin
        seen      <= 1'b0;
        seen_code <= 4'h0;
      end else if (!seen && col_hit) begin
        seen      <= 1'b1;
        seen_code <= {hit_row, col_idx};
      end
    end
  end

  always_comb begin
    accept = 1'b0;
    if (scan_end && res_valid) begin
      case (state)
        IDLE:     accept = (DEBOUNCE_SCANS <= 1);
        DEBOUNCE: accept = (res_code == cand) && (int'(db_cnt) + 1 >= DEBOUNCE_SCANS);
        default:  accept = 1'b0;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt;

  assign rep_fire = scan_end && (state == PRESSED) && res_valid &&
                    (int'(rep_cnt) + 1 >= REPEAT_SCANS);
`else
  assign rep_fire = 1'b0;
`endif

  assign emit      = accept | rep_fire;
  assign emit_code = (state == PRESSED) ? cand : res_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'h0;
      db_cnt    <= '0;
      rel_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      value     <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= emit;
      if (emit) key_code <= emit_code;

      // Clear beats a same-cycle push; the push is dropped.
      if (clear) begin
        value <= 16'h0000;
      end else if (emit) begin
        value <= {value[11:0], emit_code};
      end

      if (scan_end) begin
        case (state)
          IDLE: begin
            if (res_valid) begin
              cand <= res_code;
              if (accept) begin
                state   <= PRESSED;
                rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt <= '0;
`endif
              end else begin
                state  <= DEBOUNCE;
                db_cnt <= CW'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (!res_valid) begin
              state  <= IDLE;
              db_cnt <= '0;
            end else if (res_code != cand) begin
              cand   <= res_code;
              db_cnt <= CW'(1);
            end else if (accept) begin
              state   <= PRESSED;
              db_cnt  <= '0;
              rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (res_valid) begin
              rel_cnt <= '0;
            end else if (int'(rel_cnt) + 1 >= DEBOUNCE_SCANS) begin
              state   <= IDLE;
              rel_cnt <= '0;
            end else begin
              rel_cnt <= rel_cnt + 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (int'(rep_cnt) + 1 >= REPEAT_SCANS) begin
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4: a scan-level keypad model plus hand-computed key sequences.
module tb_keypad_scanner_4x4;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP      = 8;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic        clear;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic [1:0]  dbg_state;

  logic [15:0] keys;
  logic [15:0] keys_d;
  logic        clear_d;
  int          edge_cnt;
  int          checks;
  int          errors;
  int          pulses;

  int          hist[$];
  bit          m_pressed;
  int          m_key;
  int          m_rep;
  int          res;
  bit          emit;
  logic        exp_valid;
  logic [3:0]  exp_code;
  logic [15:0] exp_value;
  logic [3:0]  exp_col;

  keypad_scanner_4x4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .clear     (clear),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_cnt = 0;
    checks   = 0;
    errors   = 0;
    pulses   = 0;
    keys_d   = 16'h0;
    clear_d  = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Passive keypad: key bit r*4+c shorts row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*4 +: 4] & col);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_key(input logic [15:0] m);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (m[r*4 + c]) return r*4 + c;
      end
    end
    return -1;
  endfunction

  function automatic bit hist_all(input int k);
    if (hist.size() != DB) return 1'b0;
    foreach (hist[i]) if (hist[i] != k) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard: scan-level model, compared on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hist.delete();
      m_pressed = 1'b0;
      m_key     = 0;
      m_rep     = 0;
      exp_valid = 1'b0;
      exp_code  = 4'h0;
      exp_value = 16'h0;
    end else begin
      emit = 1'b0;
      if (edge_cnt > 0 && edge_cnt % SCAN_CYC == 0) begin
        res = first_key(keys_d);
        hist.push_back(res);
        if (hist.size() > DB) void'(hist.pop_front());
        if (!m_pressed) begin
          if (res >= 0 && hist_all(res)) begin
            m_pressed = 1'b1;
            m_key     = res;
            m_rep     = 0;
            emit      = 1'b1;
          end
        end else if (hist_all(-1)) begin
          m_pressed = 1'b0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else begin
          m_rep++;
          if (m_rep == REP) begin
            m_rep = 0;
            if (res >= 0) emit = 1'b1;
          end
        end
`endif
      end
      if (emit) exp_code = 4'(m_key);
      if (clear_d)   exp_value = 16'h0;
      else if (emit) exp_value = {exp_value[11:0], 4'(m_key)};
      exp_valid = emit;
    end
    exp_col = 4'b0001 << ((edge_cnt / SCAN_DIV) % 4);
    check("col", col, exp_col);
    check("key_valid", key_valid, exp_valid);
    check("key_code", key_code, exp_code);
    check("value", value, exp_value);
    if (key_valid === 1'b1) pulses++;
    keys_d  = keys;
    clear_d = clear;
  end

  // Driver: called just after a scan-end edge; holds a key mask for n full scans.
  task automatic scans(input logic [15:0] mask, input int n);
    keys = mask;
    repeat (SCAN_CYC * n) @(posedge clk);
    #1;
  endtask

  logic [3:0] col_tab[5];
  int         p0;

  initial begin
    col_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    clear = 1'b0;
    keys  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", col, 4'b0001);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_value", value, 16'h0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    // Column walk
    for (int i = 0; i < 5; i++) begin
      check("col_walk", col, col_tab[i]);
      repeat (SCAN_DIV) @(posedge clk);
      #1;
    end
    repeat (2 * SCAN_CYC - 5 * SCAN_DIV) @(posedge clk);
    #1;

    // Single key (r1,c2)
    p0 = pulses;
    scans(16'h0040, 6);
    scans(16'h0, 4);
    check("t2_pulses", pulses - p0, 1);
    check("t2_code", key_code, 4'h6);
    check("t2_value", value, 16'h0006);

    // Sequence 1,2,3,4
    p0 = pulses;
    for (int k = 1; k <= 4; k++) begin
      scans(16'h1 << k, 4);
      scans(16'h0, 4);
    end
    check("t3_pulses", pulses - p0, 4);
    check("t3_value", value, 16'h1234);

    // Bounce: one scan only
    p0 = pulses;
    scans(16'h0400, 1);
    scans(16'h0, 4);
    check("t4_pulses", pulses - p0, 0);
    check("t4_value", value, 16'h1234);

    // Two keys: (r2,c1) precedes (r0,c3) in scan order
    p0 = pulses;
    scans(16'h0208, 4);
    scans(16'h0, 4);
    check("t5_pulses", pulses - p0, 1);
    check("t5_code", key_code, 4'h9);
    check("t5_value", value, 16'h2349);

    // Reset during debounce
    p0 = pulses;
    scans(16'h8000, 1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_rst_value", value, 16'h0);
    check("t6_rst_code", key_code, 4'h0);
    rst_n = 1'b1;
    scans(16'h8000, 1);
    check("t6_one_scan", pulses - p0, 0);
    scans(16'h8000, 1);
    scans(16'h0, 4);
    check("t6_pulses", pulses - p0, 1);
    check("t6_value", value, 16'h000F);

    // Clear on the same edge as the accepting push of (r1,c1)
    p0 = pulses;
    keys = 16'h0020;
    repeat (2 * SCAN_CYC - 1) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    scans(16'h0, 4);
    check("t7_pulses", pulses - p0, 1);
    check("t7_code", key_code, 4'h5);
    check("t7_value", value, 16'h0000);

    // Next key after clear
    scans(16'h0080, 3);
    scans(16'h0, 4);
    check("t7_after", value, 16'h0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout: got no finish expected finish by 1ms");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
